cpu8: RTL and testbench

- 8-bit accumulator/register CPU with a 256-byte on-chip instruction memory, loaded byte-serially over a write port, and a 2-cycle fetch/execute core.
- Top-level processing block. It exposes pc, current instruction, last ALU result and flags for observation.

---
 rtl/cpu8_pkg.sv | 40 ++++
 rtl/cpu8_alu.sv | 54 +++++
 rtl/cpu8.sv | 125 ++++++++++++
 tb/tb_cpu8.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/cpu8_pkg.sv
// Shared encodings for the cpu8 accumulator/register core: instruction classes,
// ALU operations, branch conditions, flag bit positions and control states.
package cpu8_pkg;

  localparam int IMEM_DEPTH = 256;
  localparam int NUM_REGS   = 8;

  localparam logic [1:0] CLS_ALU = 2'b00;
  localparam logic [1:0] CLS_MOV = 2'b01;
  localparam logic [1:0] CLS_BR  = 2'b10;
  localparam logic [1:0] CLS_IMM = 2'b11;

  typedef enum logic [2:0] {
    ALU_PASS = 3'b000,
    ALU_ADD  = 3'b001,
    ALU_SUB  = 3'b010,
    ALU_AND  = 3'b011,
    ALU_OR   = 3'b100,
    ALU_XOR  = 3'b101,
    ALU_SHL  = 3'b110,
    ALU_CMP  = 3'b111
  } alu_op_t;

  localparam logic [1:0] BR_JMP  = 2'b00;
  localparam logic [1:0] BR_JZ   = 2'b01;
  localparam logic [1:0] BR_JC   = 2'b10;
  localparam logic [1:0] BR_HALT = 2'b11;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

endpackage

// File: rtl/cpu8_alu.sv
// Combinational 8-bit ALU: result, Z/C/N/V flags and a writeback enable
// (CMP computes flags only).
module cpu8_alu
  import cpu8_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  alu_op_t    op,
  input  logic [7:0] flags_in,
  output logic [7:0] result,
  output logic [7:0] flags_out,
  output logic       wb_en
);

  logic [8:0] sum9;
  logic [8:0] diff9;

  assign sum9  = {1'b0, a} + {1'b0, b};
  assign diff9 = {1'b0, a} - {1'b0, b};

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    result    = b;
    flags_out = flags_in;
    wb_en     = 1'b1;
    flags_out[FLAG_C] = 1'b0;
    flags_out[FLAG_V] = 1'b0;
    unique case (op)
      ALU_PASS: result = b;
      ALU_ADD: begin
        result = sum9[7:0];
        flags_out[FLAG_C] = sum9[8];
        flags_out[FLAG_V] = (a[7] == b[7]) && (sum9[7] != a[7]);
      end
      ALU_SUB, ALU_CMP: begin
        result = diff9[7:0];
        flags_out[FLAG_C] = diff9[8];
        flags_out[FLAG_V] = (a[7] != b[7]) && (diff9[7] != a[7]);
        wb_en = (op != ALU_CMP);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SHL: begin
        result = {a[6:0], 1'b0};
        flags_out[FLAG_C] = a[7];
      end
      default: result = b;
    endcase
    flags_out[FLAG_Z] = (result == 8'h00);
    flags_out[FLAG_N] = result[7];
  end

endmodule

// File: rtl/cpu8.sv
// cpu8 top: byte-serially loaded 256-byte instruction memory, 8x8 register file
// and a FETCH/EXEC/HALT control FSM driving the cpu8_alu datapath.
module cpu8
  import cpu8_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ins_write,
  input  logic [7:0] instruction_write_data,
  output logic [7:0] pc,
  output logic [7:0] instruction,
  output logic [7:0] alu_result,
  output logic [7:0] flag
);

  logic [7:0] mem [IMEM_DEPTH];
  logic [7:0] regs [NUM_REGS];
  logic [7:0] wptr;
  state_t     state, state_nxt;

  logic [1:0] cls;
  logic [2:0] r_hi, r_lo;
  logic [7:0] operand;
  logic [7:0] alu_a, alu_b, alu_y, alu_flags;
  logic       alu_wb;
  logic       br_taken;

  assign cls     = instruction[7:6];
  assign r_hi    = instruction[5:3];
  assign r_lo    = instruction[2:0];
  assign operand = mem[pc];

  // NOTE: the memory has no reset; a reset only rewinds wptr, so program bytes survive.
  always_ff @(posedge clk) begin
    if (ins_write) mem[wptr] <= instruction_write_data;
  end

  always_comb begin
    alu_a = regs[0];
    alu_b = regs[r_lo];
    if (cls == CLS_IMM) begin
      alu_a = regs[r_lo];
      alu_b = operand;
    end
  end

  cpu8_alu u_alu (
    .a         (alu_a),
    .b         (alu_b),
    .op        (alu_op_t'(r_hi)),
    .flags_in  (flag),
    .result    (alu_y),
    .flags_out (alu_flags),
    .wb_en     (alu_wb)
  );

  always_comb begin
    br_taken = 1'b0;
    unique case (instruction[5:4])
      BR_JMP:  br_taken = 1'b1;
      BR_JZ:   br_taken = flag[FLAG_Z];
      BR_JC:   br_taken = flag[FLAG_C];
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    if (ins_write) begin
      state_nxt = FETCH;
    end else begin
      unique case (state)
        FETCH:   state_nxt = EXEC;
        EXEC:    state_nxt = (cls == CLS_BR && instruction[5:4] == BR_HALT) ? HALT : FETCH;
        HALT:    state_nxt = HALT;
        default: state_nxt = FETCH;
      endcase
    end
  end

  // NOTE: all sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= FETCH;
      pc          <= 8'h00;
      instruction <= 8'h00;
      alu_result  <= 8'h00;
      flag        <= 8'h00;
      wptr        <= 8'h00;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
    end else begin
      state <= state_nxt;
      if (ins_write) begin
        wptr <= wptr + 8'd1;
        pc   <= 8'h00;
      end else if (state == FETCH) begin
        instruction <= operand;
        pc          <= pc + 8'd1;
      end else if (state == EXEC) begin
        unique case (cls)
          CLS_ALU: begin
            if (alu_wb) regs[0] <= alu_y;
            alu_result <= alu_y;
            flag       <= alu_flags;
          end
          CLS_MOV: begin
            regs[r_hi] <= regs[r_lo];
            alu_result <= regs[r_lo];
          end
          CLS_BR: begin
            if (instruction[5:4] != BR_HALT)
              pc <= br_taken ? operand : pc + 8'd1;
          end
          default: begin
            if (alu_wb) regs[r_lo] <= alu_y;
            alu_result <= alu_y;
            flag       <= alu_flags;
            pc         <= pc + 8'd1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu8.sv
// Directed self-checking bench for cpu8: loads short programs and compares
// pc/instruction/alu_result/flag against hand-computed values.
module tb_cpu8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ins_write = 1'b0;
  logic [7:0] instruction_write_data = 8'h00;
  logic [7:0] pc, instruction, alu_result, flag;

  int checks = 0;
  int errors = 0;

  cpu8 dut (
    .clk                    (clk),
    .reset                  (reset),
    .ins_write              (ins_write),
    .instruction_write_data (instruction_write_data),
    .pc                     (pc),
    .instruction            (instruction),
    .alu_result             (alu_result),
    .flag                   (flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", name, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    tick(1);
  endtask

  task automatic load(input logic [7:0] bytes [$]);
    foreach (bytes[i]) begin
      ins_write = 1'b1;
      instruction_write_data = bytes[i];
      tick(1);
    end
    ins_write = 1'b0;
  endtask

  initial begin
    // Reset state
    reset = 1'b0;
    #3;
    check("rst_pc", pc, 8'h00);
    check("rst_flag", flag, 8'h00);
    reset = 1'b1;
    tick(1);

    // LDI-style ADD imm then HALT
    load('{8'hC9, 8'h0A, 8'hBF});
    tick(2);
    check("t1_alu", alu_result, 8'h0A);
    check("t1_flag", flag, 8'h00);
    check("t1_pc", pc, 8'h02);
    check("t1_ins", instruction, 8'hC9);
    tick(2);
    check("t1_halt_pc", pc, 8'h03);
    tick(5);
    check("t1_frozen_pc", pc, 8'h03);

    // Carry out to zero
    do_reset();
    load('{8'hC8, 8'hFF, 8'hC8, 8'h01, 8'hBF});
    tick(4);
    check("t2_alu", alu_result, 8'h00);
    check("t2_flag", flag, 8'h03);

    // CMP then JZ over an LDI
    do_reset();
    load('{8'hC9, 8'h05, 8'hF9, 8'h05, 8'h90, 8'h08, 8'hC9, 8'h63, 8'hBF});
    tick(4);
    check("t3_cmp_flag", flag, 8'h01);
    tick(8);
    check("t3_alu", alu_result, 8'h00);
    check("t3_pc", pc, 8'h09);
    check("t3_ins", instruction, 8'hBF);

    // Signed overflow
    do_reset();
    load('{8'hC8, 8'h7F, 8'hC8, 8'h01, 8'hBF});
    tick(4);
    check("t4_alu", alu_result, 8'h80);
    check("t4_flag", flag, 8'h0C);

    // Async reset in EXEC, memory retained
    do_reset();
    load('{8'hC9, 8'h0A, 8'hBF});
    tick(1);
    check("t5_pre_pc", pc, 8'h01);
    #2;
    reset = 1'b0;
    #1;
    check("t5_rst_pc", pc, 8'h00);
    check("t5_rst_ins", instruction, 8'h00);
    check("t5_rst_alu", alu_result, 8'h00);
    reset = 1'b1;
    tick(2);
    check("t5_rerun_alu", alu_result, 8'h0A);
    check("t5_rerun_pc", pc, 8'h02);

    // ins_write during EXEC discards the instruction
    do_reset();
    load('{8'hC9, 8'h0A, 8'hBF});
    tick(1);
    load('{8'h00});
    check("t6_discard_alu", alu_result, 8'h00);
    check("t6_discard_pc", pc, 8'h00);

    // HALT released by ins_write; wptr keeps appending
    do_reset();
    load('{8'hBF});
    tick(4);
    check("t7_halt_pc", pc, 8'h01);
    load('{8'h40});
    check("t7_reload_pc", pc, 8'h00);
    tick(2);
    do_reset();
    load('{8'h80});
    tick(2);
    check("t7_jmp_target", pc, 8'h40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
